// File: rtl/mem_req_sequencer.sv
// Scripted multi-processor request sequencer: drives one processor lane per script
// entry, samples that lane's response after a fixed latency and counts mismatches.
//
// state | meaning
// IDLE  | waiting for start; script loads accepted; lanes idle
// ISSUE | register entry idx onto its processor lane
// WAIT  | response latency countdown; lanes hold
// CHECK | compare selected dout lane with expected byte, advance or finish
// DONE  | result held; lanes return idle; loads and restart accepted
module mem_req_sequencer #(
  parameter int                    NUM_PROC     = 4,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    SCRIPT_DEPTH = 16,
  parameter int                    LATENCY      = 2,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR    = '0,
  parameter int                    ERR_W        = 8,
  localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1,
  localparam int IW = (SCRIPT_DEPTH > 1) ? $clog2(SCRIPT_DEPTH) : 1,
  localparam int CW = $clog2(SCRIPT_DEPTH + 1)
) (
  input  logic                           plusclk,
  input  logic                           rst,
  input  logic                           load_en,
  input  logic [IW-1:0]                  load_idx,
  input  logic [PW-1:0]                  load_proc,
  input  logic [ADDR_WIDTH-1:0]          load_addr,
  input  logic [DATA_WIDTH-1:0]          load_din,
  input  logic [DATA_WIDTH-1:0]          load_exp,
  input  logic                           load_chk,
  input  logic [CW-1:0]                  num_entries,
  input  logic                           start,
  output logic [NUM_PROC*ADDR_WIDTH-1:0] addr_proc,
  output logic [NUM_PROC*DATA_WIDTH-1:0] din_proc,
  input  logic [NUM_PROC*DATA_WIDTH-1:0] dout_proc,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [ERR_W-1:0]               err_count,
  output logic [IW-1:0]                  err_idx
);

  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(SCRIPT_DEPTH);
  localparam logic [WW-1:0] WAIT_INIT = WW'(LATENCY - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [PW-1:0]         scr_proc [SCRIPT_DEPTH];
  logic [ADDR_WIDTH-1:0] scr_addr [SCRIPT_DEPTH];
  logic [DATA_WIDTH-1:0] scr_din  [SCRIPT_DEPTH];
  logic [DATA_WIDTH-1:0] scr_exp  [SCRIPT_DEPTH];
  logic                  scr_chk  [SCRIPT_DEPTH];

  logic [IW-1:0]         idx;
  logic [IW-1:0]         last_idx;
  logic [WW-1:0]         wait_cnt;
  logic [PW-1:0]         cur_proc;
  logic [DATA_WIDTH-1:0] cur_exp;
  logic                  cur_chk;

  logic                  idle_like;
  logic [31:0]           load_idx_wide;
  logic                  load_ok;
  logic [CW-1:0]         run_len;
  logic                  empty;
  logic                  last;
  logic [DATA_WIDTH-1:0] dout_sel;
  logic                  mismatch;

  assign idle_like     = (state == S_IDLE) || (state == S_DONE);
  assign load_idx_wide = 32'(load_idx);
  assign load_ok       = idle_like && load_en && (load_idx_wide < 32'(SCRIPT_DEPTH));
  assign run_len       = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
  assign empty         = (num_entries == '0);
  assign last          = (idx == last_idx);

  always_comb begin
    dout_sel = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      if (cur_proc == PW'(k)) dout_sel = dout_proc[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign mismatch = cur_chk && (dout_sel != cur_exp);

  // Script storage is deliberately not reset.
  always_ff @(posedge plusclk) begin
    if (load_ok) begin
      scr_proc[load_idx] <= load_proc;
      scr_addr[load_idx] <= load_addr;
      scr_din[load_idx]  <= load_din;
      scr_exp[load_idx]  <= load_exp;
      scr_chk[load_idx]  <= load_chk;
    end
  end

  always_ff @(posedge plusclk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (start) next_state = empty ? S_DONE : S_ISSUE;
      S_ISSUE:        next_state = (LATENCY > 1) ? S_WAIT : S_CHECK;
      S_WAIT:         if (wait_cnt <= WAIT_LAST) next_state = S_CHECK;
      S_CHECK:        next_state = last ? S_DONE : S_ISSUE;
      default:        next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge plusclk) begin
    if (rst) begin
      addr_proc <= {NUM_PROC{IDLE_ADDR}};
      din_proc  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_idx   <= '0;
      idx       <= '0;
      last_idx  <= '0;
      wait_cnt  <= '0;
      cur_proc  <= '0;
      cur_exp   <= '0;
      cur_chk   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          addr_proc <= {NUM_PROC{IDLE_ADDR}};
          din_proc  <= '0;
          if (start) begin
            idx       <= '0;
            last_idx  <= IW'(run_len - 1'b1);
            err_count <= '0;
            err_idx   <= '0;
            done      <= empty;
            pass      <= empty;
            busy      <= !empty;
          end
        end
        S_ISSUE: begin
          for (int k = 0; k < NUM_PROC; k++) begin
            if (scr_proc[idx] == PW'(k)) begin
              addr_proc[k*ADDR_WIDTH +: ADDR_WIDTH] <= scr_addr[idx];
              din_proc[k*DATA_WIDTH +: DATA_WIDTH]  <= scr_din[idx];
            end else begin
              addr_proc[k*ADDR_WIDTH +: ADDR_WIDTH] <= IDLE_ADDR;
              din_proc[k*DATA_WIDTH +: DATA_WIDTH]  <= '0;
            end
          end
          cur_proc <= scr_proc[idx];
          cur_exp  <= scr_exp[idx];
          cur_chk  <= scr_chk[idx];
          wait_cnt <= WAIT_INIT;
        end
        S_WAIT: wait_cnt <= wait_cnt - 1'b1;
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) err_idx <= idx;
          end
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= !mismatch && (err_count == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer: a byte-memory model answers every lane
// (addr bit 31 = write), and a second instance covers error-counter saturation.
module tb_mem_req_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, load_en, load_chk, start;
  logic [3:0]   load_idx;
  logic [1:0]   load_proc;
  logic [31:0]  load_addr;
  logic [7:0]   load_din, load_exp;
  logic [4:0]   num_entries;
  logic [127:0] addr_proc;
  logic [31:0]  din_proc;
  logic [31:0]  dout_proc;
  logic         busy, done, pass;
  logic [7:0]   err_count;
  logic [3:0]   err_idx;

  logic         b_load_en, b_load_chk, b_start, b_busy, b_done, b_pass;
  logic [8:0]   b_load_idx, b_num, b_err_idx;
  logic [0:0]   b_load_proc;
  logic [7:0]   b_load_addr, b_load_din, b_load_exp, b_addr, b_din, b_err;
  logic [7:0]   b_dout = 8'h00;

  int checks = 0;
  int passed = 0;

  logic [7:0] mem [256];

  always_comb begin
    dout_proc = '0;
    for (int k = 0; k < 4; k++) dout_proc[k*8 +: 8] = mem[addr_proc[k*32 +: 8]];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h0F;
    end else begin
      for (int k = 0; k < 4; k++)
        if (addr_proc[k*32+31]) mem[addr_proc[k*32 +: 8]] <= din_proc[k*8 +: 8];
    end
  end

  mem_req_sequencer dut (
    .plusclk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
    .load_proc(load_proc), .load_addr(load_addr), .load_din(load_din),
    .load_exp(load_exp), .load_chk(load_chk), .num_entries(num_entries),
    .start(start), .addr_proc(addr_proc), .din_proc(din_proc),
    .dout_proc(dout_proc), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_idx(err_idx)
  );

  mem_req_sequencer #(
    .NUM_PROC(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .SCRIPT_DEPTH(320),
    .LATENCY(1), .IDLE_ADDR(8'h00), .ERR_W(8)
  ) dut_sat (
    .plusclk(clk), .rst(rst), .load_en(b_load_en), .load_idx(b_load_idx),
    .load_proc(b_load_proc), .load_addr(b_load_addr), .load_din(b_load_din),
    .load_exp(b_load_exp), .load_chk(b_load_chk), .num_entries(b_num),
    .start(b_start), .addr_proc(b_addr), .din_proc(b_din),
    .dout_proc(b_dout), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .err_idx(b_err_idx)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int i, input int p, input logic [31:0] a,
                      input logic [7:0] d, input logic [7:0] e, input logic c);
    load_en = 1'b1; load_idx = 4'(i); load_proc = 2'(p);
    load_addr = a; load_din = d; load_exp = e; load_chk = c;
    tick();
    load_en = 1'b0;
  endtask

  task automatic run(input int n);
    num_entries = 5'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL reset_pass: got %b want 0", pass); else passed++;
    checks++; if (err_count !== 8'h00) $display("FAIL reset_err_count: got %h want 00", err_count); else passed++;
    checks++; if (err_idx !== 4'h0) $display("FAIL reset_err_idx: got %h want 0", err_idx); else passed++;
    checks++; if (addr_proc !== 128'h0) $display("FAIL reset_addr: got %h want 0", addr_proc); else passed++;
    checks++; if (din_proc !== 32'h0) $display("FAIL reset_din: got %h want 0", din_proc); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_hit();
    int hold = 0, done_at = 0, bsy = 0;
    load(0, 0, 32'h04B0_0002, 8'h00, 8'h0F, 1'b1);
    run(1);
    for (int c = 1; c <= 8; c++) begin
      if (addr_proc[31:0] == 32'h04B0_0002) hold++;
      if (busy) bsy++;
      if (done && done_at == 0) done_at = c;
      tick();
    end
    checks++; if (hold != 3) $display("FAIL hit_lane_hold: got %0d cycles want 3", hold); else passed++;
    checks++; if (done_at != 4) $display("FAIL hit_done_cycle: got %0d want 4", done_at); else passed++;
    checks++; if (bsy != 3) $display("FAIL hit_busy_cycles: got %0d want 3", bsy); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL hit_pass: got %b want 1", pass); else passed++;
    checks++; if (err_count !== 8'h00) $display("FAIL hit_err_count: got %h want 00", err_count); else passed++;
    checks++; if (addr_proc !== 128'h0) $display("FAIL hit_lanes_idle: got %h want 0", addr_proc); else passed++;
  endtask

  task automatic test_mismatch();
    int bsy = 0, done_at = 0, multi = 0, din_bad = 0;
    logic [3:0] nz;
    logic [3:0] seen = 4'h0;
    for (int k = 0; k < 4; k++)
      load(k, k, 32'h10 + 32'(k), 8'(8'h30 + k), (k == 2) ? 8'hAA : 8'h0F, 1'b1);
    run(4);
    for (int c = 1; c <= 20; c++) begin
      for (int k = 0; k < 4; k++) nz[k] = (addr_proc[k*32 +: 32] != 32'h0);
      if ($countones(nz) > 1) multi++;
      seen = seen | nz;
      for (int k = 0; k < 4; k++) begin
        if (nz[k] && din_proc[k*8 +: 8] != 8'(8'h30 + k)) din_bad++;
        if (!nz[k] && din_proc[k*8 +: 8] != 8'h00) din_bad++;
      end
      if (busy) bsy++;
      if (done && done_at == 0) done_at = c;
      tick();
    end
    checks++; if (bsy != 12) $display("FAIL mm_busy_cycles: got %0d want 12", bsy); else passed++;
    checks++; if (done_at != 13) $display("FAIL mm_done_cycle: got %0d want 13", done_at); else passed++;
    checks++; if (multi != 0) $display("FAIL mm_other_lanes: got %0d bad cycles want 0", multi); else passed++;
    checks++; if (seen !== 4'hF) $display("FAIL mm_lanes_seen: got %b want 1111", seen); else passed++;
    checks++; if (din_bad != 0) $display("FAIL mm_din_lanes: got %0d bad want 0", din_bad); else passed++;
    checks++; if (err_count !== 8'h01) $display("FAIL mm_err_count: got %h want 01", err_count); else passed++;
    checks++; if (err_idx !== 4'h2) $display("FAIL mm_err_idx: got %h want 2", err_idx); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL mm_pass: got %b want 0", pass); else passed++;
  endtask

  task automatic test_empty();
    run(0);
    checks++; if (done !== 1'b1) $display("FAIL empty_done: got %b want 1", done); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL empty_pass: got %b want 1", pass); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL empty_busy: got %b want 0", busy); else passed++;
    checks++; if (err_count !== 8'h00) $display("FAIL empty_err_count: got %h want 00", err_count); else passed++;
    tick();
  endtask

  task automatic test_write_read();
    logic [7:0] wr_din = 8'h00;
    load(0, 1, 32'h8000_0020, 8'h5A, 8'h00, 1'b0);
    load(1, 2, 32'h0000_0020, 8'h00, 8'h5A, 1'b1);
    run(2);
    for (int c = 1; c <= 40 && !done; c++) begin
      if (c == 2) wr_din = din_proc[15:8];
      tick();
    end
    checks++; if (done !== 1'b1) $display("FAIL wr_done: got %b want 1", done); else passed++;
    checks++; if (wr_din !== 8'h5A) $display("FAIL wr_din_lane1: got %h want 5a", wr_din); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL wr_pass: got %b want 1", pass); else passed++;
    checks++; if (err_count !== 8'h00) $display("FAIL wr_err_count: got %h want 00", err_count); else passed++;
    tick();
  endtask

  task automatic test_clamp();
    int bsy = 0, done_at = 0;
    for (int k = 0; k < 16; k++)
      load(k, k % 4, 32'h40 + 32'(k), 8'h00, (k == 15) ? 8'hAA : 8'h00, k == 15);
    run(17);
    for (int c = 1; c <= 60; c++) begin
      if (busy) bsy++;
      if (done && done_at == 0) done_at = c;
      tick();
    end
    checks++; if (bsy != 48) $display("FAIL clamp_busy_cycles: got %0d want 48", bsy); else passed++;
    checks++; if (done_at != 49) $display("FAIL clamp_done_cycle: got %0d want 49", done_at); else passed++;
    checks++; if (err_count !== 8'h01) $display("FAIL clamp_err_count: got %h want 01", err_count); else passed++;
    checks++; if (err_idx !== 4'hF) $display("FAIL clamp_err_idx: got %h want f", err_idx); else passed++;
  endtask

  task automatic test_protocol();
    int bsy = 0, done_at = 0;
    load(0, 0, 32'h10, 8'h00, 8'h0F, 1'b1);
    load(1, 3, 32'h11, 8'h00, 8'h0F, 1'b1);
    run(2);
    for (int c = 1; c <= 15; c++) begin
      if (busy) bsy++;
      if (done && done_at == 0) done_at = c;
      if (c == 2) begin
        start = 1'b1; num_entries = 5'd0;
        load_en = 1'b1; load_idx = 4'd1; load_exp = 8'hAA; load_chk = 1'b1;
      end
      if (c == 3) begin
        start = 1'b0; load_en = 1'b0;
      end
      tick();
    end
    checks++; if (bsy != 6) $display("FAIL proto_busy_cycles: got %0d want 6", bsy); else passed++;
    checks++; if (done_at != 7) $display("FAIL proto_done_cycle: got %0d want 7", done_at); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL proto_pass: got %b want 1", pass); else passed++;
    checks++; if (err_count !== 8'h00) $display("FAIL proto_err_count: got %h want 00", err_count); else passed++;
    run(2);
    for (int c = 1; c <= 40 && !done; c++) tick();
    checks++; if (done !== 1'b1) $display("FAIL proto_rerun_done: got %b want 1", done); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL proto_rerun_pass: got %b want 1", pass); else passed++;
    tick();
  endtask

  task automatic test_mid_reset();
    run(2);
    tick();
    tick();
    checks++; if (addr_proc[31:0] !== 32'h10) $display("FAIL mrst_lane_active: got %h want 00000010", addr_proc[31:0]); else passed++;
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL mrst_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL mrst_done: got %b want 0", done); else passed++;
    checks++; if (addr_proc !== 128'h0) $display("FAIL mrst_lanes: got %h want 0", addr_proc); else passed++;
    rst = 1'b0;
    tick();
    load_en = 1'b1; load_idx = 4'd0; load_proc = 2'd0; load_addr = 32'h10;
    load_din = 8'h00; load_exp = 8'hAA; load_chk = 1'b1;
    run(1);
    load_en = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) tick();
    checks++; if (done !== 1'b1) $display("FAIL ldstart_done: got %b want 1", done); else passed++;
    checks++; if (err_count !== 8'h01) $display("FAIL ldstart_err_count: got %h want 01", err_count); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL ldstart_pass: got %b want 0", pass); else passed++;
    load(0, 0, 32'h10, 8'h00, 8'h0F, 1'b1);
    run(2);
    for (int c = 1; c <= 20 && !done; c++) tick();
    checks++; if (done !== 1'b1) $display("FAIL clean_done: got %b want 1", done); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL clean_pass: got %b want 1", pass); else passed++;
    checks++; if (err_count !== 8'h00) $display("FAIL clean_err_count: got %h want 00", err_count); else passed++;
    tick();
  endtask

  task automatic test_saturate();
    int bsy = 0, done_at = 0;
    for (int i = 0; i < 301; i++) begin
      b_load_en = 1'b1; b_load_idx = 9'(i); b_load_proc = 1'b0;
      b_load_addr = 8'(i); b_load_din = 8'(i); b_load_chk = 1'b1;
      b_load_exp = (i == 0) ? 8'h00 : 8'hFF;
      tick();
    end
    b_load_en = 1'b0;
    b_num = 9'd301; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 1; c <= 700 && done_at == 0; c++) begin
      if (b_busy) bsy++;
      if (b_done) done_at = c;
      tick();
    end
    checks++; if (bsy != 602) $display("FAIL sat_busy_cycles: got %0d want 602", bsy); else passed++;
    checks++; if (done_at != 603) $display("FAIL sat_done_cycle: got %0d want 603", done_at); else passed++;
    checks++; if (b_err !== 8'hFF) $display("FAIL sat_err_count: got %h want ff", b_err); else passed++;
    checks++; if (b_err_idx !== 9'd1) $display("FAIL sat_err_idx: got %0d want 1", b_err_idx); else passed++;
    checks++; if (b_pass !== 1'b0) $display("FAIL sat_pass: got %b want 0", b_pass); else passed++;
    checks++; if (b_addr !== 8'h00 || b_din !== 8'h00) $display("FAIL sat_lanes_idle: got %h/%h want 00/00", b_addr, b_din); else passed++;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_chk = 1'b0; start = 1'b0;
    load_idx = '0; load_proc = '0; load_addr = '0; load_din = '0; load_exp = '0;
    num_entries = '0;
    b_load_en = 1'b0; b_load_chk = 1'b0; b_start = 1'b0; b_load_idx = '0;
    b_num = '0; b_load_proc = '0; b_load_addr = '0; b_load_din = '0; b_load_exp = '0;
    test_reset();
    test_read_hit();
    test_mismatch();
    test_empty();
    test_write_read();
    test_clamp();
    test_protocol();
    test_mid_reset();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
